// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller-to-datapath/memory handshake bundle for the multi-cycle RV32I controller.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_fsm_if;
  logic [31:0] inst_code;
  logic        br_taken;
  logic        imem_ready;
  logic        dmem_ack;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        illegal;
  logic        mem_err;
  logic [2:0]  state;
  modport master (
    input  inst_code, br_taken, imem_ready, dmem_ack,
    output imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_we, wb_sel,
           alu_src, alu_op, illegal, mem_err, state
  );
  modport slave (
    output inst_code, br_taken, imem_ready, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_we, wb_sel,
           alu_src, alu_op, illegal, mem_err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I main controller (fetch/decode/exec/mem/wb).
// Only state and the MEM wait counter are registered; control outputs decode from them.
module mc_ctrl_fsm #(
  parameter int STALL_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);
  localparam int CW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic       mem_err;
  } ctrl_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctl, ctl_g;
  logic [6:0]    opc;
  logic          is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, legal;
  logic          unused_inst;
  assign opc         = bus.inst_code[6:0];
  assign unused_inst = ^bus.inst_code[31:7];
  assign is_r    = opc == 7'b0110011;
  assign is_i    = opc == 7'b0010011;
  assign is_ld   = opc == 7'b0000011;
  assign is_st   = opc == 7'b0100011;
  assign is_br   = opc == 7'b1100011;
  assign is_jal  = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;
  always_comb begin
    ctl     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      ctl.alu_src = ~(is_r | is_br);
      ctl.alu_op  = is_br ? 2'b01 : (is_r | is_i) ? 2'b10 : 2'b00;
    end
    case (state_q)
      FETCH: begin
        ctl.imem_req = 1'b1;
        ctl.ir_we    = bus.imem_ready;
        state_d      = bus.imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctl.illegal = ~legal;
        ctl.pc_we   = ~legal;
        state_d     = legal ? EXEC : FETCH;
      end
      EXEC: begin
        ctl.pc_we  = is_br | is_jal | is_jalr;
        ctl.pc_sel = is_jalr ? 2'b10 : (is_jal | (is_br & bus.br_taken)) ? 2'b01 : 2'b00;
        ctl.reg_we = is_jal | is_jalr;
        ctl.wb_sel = (is_jal | is_jalr) ? 2'b10 : 2'b00;
        state_d    = (is_r | is_i) ? WB : (is_ld | is_st) ? MEM : FETCH;
        cnt_d      = '0;
      end
      MEM: begin
        if (bus.dmem_ack) begin
          ctl.dmem_req = 1'b1;
          ctl.dmem_we  = is_st;
          ctl.pc_we    = ~is_ld;
          state_d      = is_ld ? WB : FETCH;
        end else if (cnt_q == CW'(STALL_LIMIT - 1)) begin
          // Abort: request drops in the timeout cycle so the memory sees no new transfer.
          ctl.mem_err = 1'b1;
          ctl.pc_we   = 1'b1;
          state_d     = FETCH;
        end else begin
          ctl.dmem_req = 1'b1;
          ctl.dmem_we  = is_st;
          cnt_d        = cnt_q + CW'(1);
        end
      end
      WB: begin
        ctl.reg_we = 1'b1;
        ctl.pc_we  = 1'b1;
        ctl.wb_sel = is_ld ? 2'b01 : 2'b00;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Reset gates the decoded outputs so they drop without waiting for a clock.
  assign ctl_g        = rst_n ? ctl : '0;
  assign bus.imem_req = ctl_g.imem_req;
  assign bus.ir_we    = ctl_g.ir_we;
  assign bus.pc_we    = ctl_g.pc_we;
  assign bus.pc_sel   = ctl_g.pc_sel;
  assign bus.dmem_req = ctl_g.dmem_req;
  assign bus.dmem_we  = ctl_g.dmem_we;
  assign bus.reg_we   = ctl_g.reg_we;
  assign bus.wb_sel   = ctl_g.wb_sel;
  assign bus.alu_src  = ctl_g.alu_src;
  assign bus.alu_op   = ctl_g.alu_op;
  assign bus.illegal  = ctl_g.illegal;
  assign bus.mem_err  = ctl_g.mem_err;
  assign bus.state    = state_q;
endmodule
